// File: rtl/spi_chain_pkg.sv
// Shared widths, op encodings and FSM state type for the scan-chain master.
package spi_chain_pkg;
  localparam int DATA_WIDTH  = 16;
  localparam int ADDR_WIDTH  = 7;
  localparam int TOTAL_WIDTH = DATA_WIDTH + ADDR_WIDTH;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_CAPTURE,
    ST_SHIFT_OUT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/spi_chain_master_if.sv
// Command/response bundle between the front-end and the scan-chain master.
// Handshake: a command transfers on any rising edge where cmd_valid and cmd_ready
// are both 1; rsp_valid is a one-cycle pulse with no back-pressure.
interface spi_chain_master_if;
  import spi_chain_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  state_t                fsm_state;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_addr, fsm_state
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_addr, fsm_state
  );
endinterface

// File: rtl/spi_phase_gen.sv
// Bit-slot timing: four quarters per slot, non-overlapping phase clocks and slot pulses.
module spi_phase_gen #(
  parameter int QUARTER_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic clk_phase1,
  output logic clk_phase2,
  output logic slot_start,
  output logic sample_strobe,
  output logic slot_end
);
  localparam int QW = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(QUARTER_CYCLES - 1);

  logic [QW-1:0] qcnt;
  logic [1:0]    quarter;
  logic          q_end;

  assign q_end = (qcnt == Q_LAST);

  // Counters sit at zero whenever the chain is not being clocked, so every
  // shifting state begins on a fresh Q0.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      qcnt    <= '0;
      quarter <= 2'd0;
    end else if (q_end) begin
      qcnt    <= '0;
      quarter <= (quarter == 2'd3) ? 2'd0 : quarter + 2'd1;
    end else begin
      qcnt    <= qcnt + QW'(1);
    end
  end

  assign clk_phase1    = run && (quarter == 2'd1);
  assign clk_phase2    = run && (quarter == 2'd3);
  assign slot_start    = run && (quarter == 2'd0) && (qcnt == '0);
  assign slot_end      = run && (quarter == 2'd3) && q_end;
  assign sample_strobe = slot_end;
endmodule

// File: rtl/spi_chain_master.sv
// Scan-chain master: frames commands onto the two-phase chain and returns the frame shifted out.
module spi_chain_master
  import spi_chain_pkg::*;
#(
  parameter int QUARTER_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  spi_chain_master_if.master  bus,
  output logic                chain_reset_n,
  output logic                clk_phase1,
  output logic                clk_phase2,
  output logic                capture,
  output logic                spi_din,
  input  logic                spi_out
);
  localparam int BW = $clog2(TOTAL_WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(TOTAL_WIDTH - 1);

  state_t                 state, state_n;
  logic                   op_q;
  logic [BW-1:0]          bit_cnt;
  logic [TOTAL_WIDTH-1:0] tx, rx, rx_next;
  logic [DATA_WIDTH-1:0]  rsp_data_q;
  logic [ADDR_WIDTH-1:0]  rsp_addr_q;
  logic                   handshake, shifting, run, bit_last;
  logic                   slot_start, sample_strobe, slot_end;

  assign handshake = bus.cmd_valid && bus.cmd_ready;
  assign shifting  = (state == ST_SHIFT_IN) || (state == ST_SHIFT_OUT);
  assign run       = shifting || (state == ST_CAPTURE);
  assign bit_last  = (bit_cnt == BIT_LAST);
  assign rx_next   = {spi_out, rx[TOTAL_WIDTH-1:1]};

  spi_phase_gen #(.QUARTER_CYCLES(QUARTER_CYCLES)) u_phase (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .clk_phase1    (clk_phase1),
    .clk_phase2    (clk_phase2),
    .slot_start    (slot_start),
    .sample_strobe (sample_strobe),
    .slot_end      (slot_end)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:      if (handshake) state_n = ST_SHIFT_IN;
      ST_SHIFT_IN:  if (slot_end && bit_last) state_n = (op_q == OP_READ) ? ST_CAPTURE : ST_DONE;
      ST_CAPTURE:   if (slot_end) state_n = ST_SHIFT_OUT;
      ST_SHIFT_OUT: if (slot_end && bit_last) state_n = ST_DONE;
      ST_DONE:      state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    chain_reset_n <= ~reset;
    if (reset) begin
      op_q       <= OP_WRITE;
      bit_cnt    <= '0;
      tx         <= '0;
      rx         <= '0;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
    end else begin
      if (handshake) begin
        op_q    <= bus.cmd_op;
        tx      <= {(bus.cmd_op == OP_READ) ? {DATA_WIDTH{1'b0}} : bus.cmd_data, bus.cmd_addr};
        bit_cnt <= '0;
      end
      if (slot_end && shifting) bit_cnt <= bit_last ? '0 : bit_cnt + BW'(1);
      if (slot_end && (state == ST_SHIFT_IN)) tx <= tx >> 1;
      // The last sample lands on the same edge that enters DONE, so the
      // response is loaded from rx_next rather than rx.
      if (sample_strobe && shifting) rx <= rx_next;
      else if (slot_start && shifting && (bit_cnt == '0)) rx <= '0;
      if ((state_n == ST_DONE) && (state != ST_DONE)) begin
        rsp_data_q <= rx_next[TOTAL_WIDTH-1:ADDR_WIDTH];
        rsp_addr_q <= rx_next[ADDR_WIDTH-1:0];
      end
    end
  end

  assign capture       = (state == ST_CAPTURE);
  assign spi_din       = (state == ST_SHIFT_IN) && tx[0];
  assign bus.cmd_ready = (state == ST_IDLE) && !reset;
  assign bus.rsp_valid = (state == ST_DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_spi_chain_master.sv
// Bench for spi_chain_master: two instances (QUARTER_CYCLES 2 and 1), each driving a behavioural chain.
module tb_spi_chain_master;
  import spi_chain_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [1:0] rst, cmd_valid, cmd_op, cmd_ready, rsp_valid;
  logic [1:0] crn, p1, p2, cap, din, sout;
  logic [ADDR_WIDTH-1:0]  cmd_addr [2];
  logic [DATA_WIDTH-1:0]  cmd_data [2];
  logic [DATA_WIDTH-1:0]  rsp_data [2];
  logic [ADDR_WIDTH-1:0]  rsp_addr [2];
  logic [DATA_WIDTH-1:0]  cap_in   [2];
  logic [TOTAL_WIDTH-1:0] chain    [2];
  logic [TOTAL_WIDTH-1:0] exp_chain[2];
  int qc [2];
  int mon_err [2];

  spi_chain_master_if bus0 ();
  spi_chain_master_if bus1 ();

  assign bus0.cmd_valid = cmd_valid[0];
  assign bus0.cmd_op    = cmd_op[0];
  assign bus0.cmd_addr  = cmd_addr[0];
  assign bus0.cmd_data  = cmd_data[0];
  assign cmd_ready[0]   = bus0.cmd_ready;
  assign rsp_valid[0]   = bus0.rsp_valid;
  assign rsp_data[0]    = bus0.rsp_data;
  assign rsp_addr[0]    = bus0.rsp_addr;
  assign bus1.cmd_valid = cmd_valid[1];
  assign bus1.cmd_op    = cmd_op[1];
  assign bus1.cmd_addr  = cmd_addr[1];
  assign bus1.cmd_data  = cmd_data[1];
  assign cmd_ready[1]   = bus1.cmd_ready;
  assign rsp_valid[1]   = bus1.rsp_valid;
  assign rsp_data[1]    = bus1.rsp_data;
  assign rsp_addr[1]    = bus1.rsp_addr;
  assign sout = {chain[1][0], chain[0][0]};

  spi_chain_master #(.QUARTER_CYCLES(2)) dut0 (
    .clk(clk), .reset(rst[0]), .bus(bus0), .chain_reset_n(crn[0]),
    .clk_phase1(p1[0]), .clk_phase2(p2[0]), .capture(cap[0]),
    .spi_din(din[0]), .spi_out(sout[0])
  );

  spi_chain_master #(.QUARTER_CYCLES(1)) dut1 (
    .clk(clk), .reset(rst[1]), .bus(bus1), .chain_reset_n(crn[1]),
    .clk_phase1(p1[1]), .clk_phase2(p2[1]), .capture(cap[1]),
    .spi_din(din[1]), .spi_out(sout[1])
  );

  // Behavioural cell chain: phase1 rising latches din/capture, phase2 falling commits.
  logic [1:0] m_din, m_cap, p1_q, p2_q;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (crn[k] !== 1'b1) begin
        chain[k] = '0;
        m_din[k] = 1'b0;
        m_cap[k] = 1'b0;
      end else begin
        if (p1[k] && !p1_q[k]) begin
          m_din[k] = din[k];
          m_cap[k] = cap[k];
        end
        if (!p2[k] && p2_q[k])
          chain[k] = m_cap[k] ? {cap_in[k], chain[k][ADDR_WIDTH-1:0]}
                              : {m_din[k], chain[k][TOTAL_WIDTH-1:1]};
      end
      p1_q[k] = p1[k];
      p2_q[k] = p2[k];
    end
  end

  // Phase monitor: no overlap, each pulse QUARTER_CYCLES long, din moves only in Q0.
  int run1 [2];
  int run2 [2];
  logic [1:0] since_p1, din_q;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k] !== 1'b0) begin
        run1[k] = 0;
        run2[k] = 0;
        since_p1[k] = 1'b0;
      end else begin
        if (p1[k] && p2[k]) mon_err[k]++;
        if (p1[k]) run1[k]++;
        else if (run1[k] != 0) begin
          if (run1[k] != qc[k]) mon_err[k]++;
          run1[k] = 0;
        end
        if (p2[k]) run2[k]++;
        else if (run2[k] != 0) begin
          if (run2[k] != qc[k]) mon_err[k]++;
          run2[k] = 0;
        end
        if (p1[k]) since_p1[k] = 1'b1;
        if (p2[k]) since_p1[k] = 1'b0;
        if ((din[k] !== din_q[k]) && (p1[k] || p2[k] || since_p1[k])) mon_err[k]++;
      end
      din_q[k] = din[k];
    end
  end

  // Drivers: all tasks start and end 1 time unit after a rising edge.
  task automatic start_cmd(input int k, input logic op, input logic [ADDR_WIDTH-1:0] a,
                           input logic [DATA_WIDTH-1:0] d);
    int n = 0;
    cmd_op[k] = op;
    cmd_addr[k] = a;
    cmd_data[k] = d;
    cmd_valid[k] = 1'b1;
    while (cmd_ready[k] !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL start_cmd[%0d]: cmd_ready never rose", k);
    end
    @(posedge clk); #1;
    cmd_valid[k] = 1'b0;
  endtask

  task automatic wait_rsp(input int k, output int lat, output int ready_hi, output int cap_cyc);
    lat = 1;
    ready_hi = 0;
    cap_cyc = 0;
    while (rsp_valid[k] !== 1'b1 && lat < 1000) begin
      if (cmd_ready[k]) ready_hi++;
      if (cap[k]) cap_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (cmd_ready[k]) ready_hi++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({p1[k], p2[k], cap[k], din[k], rsp_valid[k], crn[k], cmd_ready[k]} !== 7'b0) begin
        failures++;
        $display("FAIL reset_outputs[%0d]: p1 p2 cap din rsp_valid crn ready = %b%b%b%b%b%b%b, want 0000000",
                 k, p1[k], p2[k], cap[k], din[k], rsp_valid[k], crn[k], cmd_ready[k]);
      end
      checks++;
      if (rsp_data[k] !== 16'h0 || rsp_addr[k] !== 7'h0) begin
        failures++;
        $display("FAIL reset_rsp[%0d]: data=%h addr=%h, want 0/0", k, rsp_data[k], rsp_addr[k]);
      end
    end
    rst = 2'b00;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (cmd_ready[k] !== 1'b1 || crn[k] !== 1'b1) begin
        failures++;
        $display("FAIL reset_release[%0d]: ready=%b crn=%b, want 1/1", k, cmd_ready[k], crn[k]);
      end
    end
  endtask

  task automatic test_write(input int k, input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    logic [TOTAL_WIDTH-1:0] prev, frame;
    int lat, rhi, cc, want;
    prev = exp_chain[k];
    frame = {d, a};
    want = 1 + 23 * 4 * qc[k];
    start_cmd(k, OP_WRITE, a, d);
    checks++;
    if (din[k] !== frame[0]) begin
      failures++;
      $display("FAIL write_first_bit[%0d]: din=%b want %b", k, din[k], frame[0]);
    end
    wait_rsp(k, lat, rhi, cc);
    checks++;
    if (lat != want) begin
      failures++;
      $display("FAIL write_latency[%0d]: got %0d want %0d", k, lat, want);
    end
    checks++;
    if (rsp_data[k] !== prev[TOTAL_WIDTH-1:ADDR_WIDTH] || rsp_addr[k] !== prev[ADDR_WIDTH-1:0]) begin
      failures++;
      $display("FAIL write_rsp[%0d]: %h/%h want %h/%h", k, rsp_data[k], rsp_addr[k],
               prev[TOTAL_WIDTH-1:ADDR_WIDTH], prev[ADDR_WIDTH-1:0]);
    end
    checks++;
    if (rhi != 0 || cc != 0) begin
      failures++;
      $display("FAIL write_busy[%0d]: ready_high=%0d capture_cycles=%0d want 0/0", k, rhi, cc);
    end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (chain[k] !== frame) begin
      failures++;
      $display("FAIL write_chain[%0d]: chain=%h want %h", k, chain[k], frame);
    end
    exp_chain[k] = frame;
  endtask

  task automatic test_read(input int k, input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] c);
    int lat, rhi, cc, want;
    cap_in[k] = c;
    want = 1 + 47 * 4 * qc[k];
    start_cmd(k, OP_READ, a, 16'($urandom));
    wait_rsp(k, lat, rhi, cc);
    checks++;
    if (lat != want) begin
      failures++;
      $display("FAIL read_latency[%0d]: got %0d want %0d", k, lat, want);
    end
    checks++;
    if (rsp_data[k] !== c || rsp_addr[k] !== a) begin
      failures++;
      $display("FAIL read_rsp[%0d]: %h/%h want %h/%h", k, rsp_data[k], rsp_addr[k], c, a);
    end
    checks++;
    if (cc != 4 * qc[k] || rhi != 0) begin
      failures++;
      $display("FAIL read_capture[%0d]: capture_cycles=%0d ready_high=%0d want %0d/0", k, cc, rhi, 4 * qc[k]);
    end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (chain[k] !== '0) begin
      failures++;
      $display("FAIL read_chain[%0d]: chain=%h want 0 after zero shift-out", k, chain[k]);
    end
    exp_chain[k] = '0;
  endtask

  task automatic test_back_to_back(input int k);
    int lat, rhi, cc;
    test_write(k, 7'h7F, 16'hFFFF);
    start_cmd(k, OP_WRITE, 7'h7F, 16'hFFFF);
    // second command is held pending while the first is in flight
    cmd_op[k] = OP_WRITE;
    cmd_addr[k] = 7'h00;
    cmd_data[k] = 16'h0001;
    cmd_valid[k] = 1'b1;
    wait_rsp(k, lat, rhi, cc);
    checks++;
    if (rhi != 0 || rsp_data[k] !== 16'hFFFF || rsp_addr[k] !== 7'h7F) begin
      failures++;
      $display("FAIL b2b_first[%0d]: ready_high=%0d rsp=%h/%h want 0 ffff/7f", k, rhi, rsp_data[k], rsp_addr[k]);
    end
    start_cmd(k, OP_WRITE, 7'h00, 16'h0001);
    wait_rsp(k, lat, rhi, cc);
    checks++;
    if (lat != 1 + 23 * 4 * qc[k] || rsp_data[k] !== 16'hFFFF || rsp_addr[k] !== 7'h7F) begin
      failures++;
      $display("FAIL b2b_second[%0d]: lat=%0d rsp=%h/%h want %0d ffff/7f", k, lat, rsp_data[k], rsp_addr[k],
               1 + 23 * 4 * qc[k]);
    end
    exp_chain[k] = {16'h0001, 7'h00};
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_mid(input int k);
    int seen = 0;
    start_cmd(k, OP_WRITE, 7'h33, 16'hBEEF);
    repeat (49) begin @(posedge clk); #1; end
    rst[k] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({p1[k], p2[k], cap[k], din[k], crn[k], cmd_ready[k], rsp_valid[k]} !== 7'b0) begin
      failures++;
      $display("FAIL reset_mid[%0d]: p1 p2 cap din crn ready rsp_valid = %b%b%b%b%b%b%b, want 0000000",
               k, p1[k], p2[k], cap[k], din[k], crn[k], cmd_ready[k], rsp_valid[k]);
    end
    @(posedge clk); #1;
    rst[k] = 1'b0;
    repeat (400) begin
      if (rsp_valid[k]) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_abort[%0d]: rsp_valid seen %0d times, want 0", k, seen);
    end
    exp_chain[k] = '0;
    test_read(k, 7'h4C, 16'h5AA5);
  endtask

  task automatic test_random(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) test_write(k, 7'($urandom), 16'($urandom));
      else                           test_read(k, 7'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_phase_monitor();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mon_err[k] != 0) begin
        failures++;
        $display("FAIL phase_monitor[%0d]: %0d violations, want 0", k, mon_err[k]);
      end
    end
  endtask

  initial begin
    qc[0] = 2;
    qc[1] = 1;
    mon_err[0] = 0;
    mon_err[1] = 0;
    rst = 2'b11;
    cmd_valid = 2'b00;
    cmd_op = 2'b00;
    for (int k = 0; k < 2; k++) begin
      cmd_addr[k] = '0;
      cmd_data[k] = '0;
      cap_in[k] = '0;
      exp_chain[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    for (int k = 0; k < 2; k++) begin
      test_write(k, 7'h15, 16'hA5C3);
      test_read(k, 7'h2A, 16'h1234);
    end
    test_back_to_back(0);
    test_reset_mid(0);
    test_random(0, 6);
    test_random(1, 6);
    test_phase_monitor();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
